// File: rtl/game_pkg.sv
// Shared definitions for the racing game: sequencer state encoding, lives width
// and the frame-counter width helper used by the sequencer and the HUD blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int LIVES_W = 3;

  // At least 4 bits so the crash blink can always use bit 3 of the timer.
  function automatic int frame_cnt_w(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    if (w < 4) begin
      w = 4;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for an already synchronised level input; a held level
// produces a single pulse.
module edge_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_r;

  // remember last cycle's level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r <= 1'b0;
    end else begin
      d_r <= d;
    end
  end

  assign pulse = d & ~d_r;

endmodule

// File: rtl/race_game_controller.sv
// Racing game sequencer: run/crash/game-over state, lives, score and respawn,
// driven once per video frame from the collision detector's flag.
module race_game_controller
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int CRASH_FRAMES = 60,
  parameter int GRACE_FRAMES = 90,
  parameter int SCORE_DIV    = 6,
  parameter int SCORE_W      = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               collision,
  output logic               game_run,
  output logic               pos_reset,
  output logic               crash_flash,
  output logic               game_over,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score
);

  localparam int CNT_W = frame_cnt_w((CRASH_FRAMES > GRACE_FRAMES) ? CRASH_FRAMES : GRACE_FRAMES);
  localparam int DIV_W = frame_cnt_w(SCORE_DIV);

  localparam logic [CNT_W-1:0]   CRASH_LOAD = CNT_W'(CRASH_FRAMES);
  localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCORE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  game_state_e        state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;      // crash timer in CRASH, grace counter in PLAY
  logic [DIV_W-1:0]   div_r, div_s;
  logic [LIVES_W-1:0] lives_r, lives_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic               pos_reset_s;
  logic               start_edge_s;
  logic               game_run_r, pos_reset_r, crash_flash_r, game_over_r;

  edge_rise_det u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start_btn),
    .pulse (start_edge_s)
  );

  // next-state, counter, lives and score logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    div_s       = div_r;
    lives_s     = lives_r;
    score_s     = score_r;
    pos_reset_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_edge_s) begin
          state_s     = ST_PLAY;
          pos_reset_s = 1'b1;
          lives_s     = LIVES_LOAD;
          score_s     = '0;
          cnt_s       = GRACE_LOAD;
          div_s       = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAY: begin
        if (frame_tick && (cnt_r == '0) && collision) begin
          state_s = ST_CRASH;
          lives_s = lives_r - LIVES_ONE;
          cnt_s   = CRASH_LOAD;
        end else if (frame_tick) begin
          if (cnt_r != '0) begin
            cnt_s = cnt_r - CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
          if (div_r == DIV_LAST) begin
            div_s = '0;
            if (score_r != SCORE_MAX) begin
              score_s = score_r + SCORE_ONE;
            end else begin
              score_s = score_r;
            end
          end else begin
            div_s = div_r + DIV_ONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CRASH: begin
        if (frame_tick) begin
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            if (lives_r == '0) begin
              state_s = ST_OVER;
            end else begin
              state_s     = ST_PLAY;
              pos_reset_s = 1'b1;
              cnt_s       = GRACE_LOAD;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      div_r         <= '0;
      lives_r       <= LIVES_LOAD;
      score_r       <= '0;
      game_run_r    <= 1'b0;
      pos_reset_r   <= 1'b0;
      crash_flash_r <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      div_r         <= div_s;
      lives_r       <= lives_s;
      score_r       <= score_s;
      game_run_r    <= (state_s == ST_PLAY);
      pos_reset_r   <= pos_reset_s;
      crash_flash_r <= (state_s == ST_CRASH) & cnt_s[3];
      game_over_r   <= (state_s == ST_OVER);
    end
  end

  assign game_run    = game_run_r;
  assign pos_reset   = pos_reset_r;
  assign crash_flash = crash_flash_r;
  assign game_over   = game_over_r;
  assign lives       = lives_r;
  assign score       = score_r;

endmodule
